// File: rtl/outbuf.sv
// outbuf: drain-side buffer for one systolic-array column.
// It drops the leading PADDING samples of every contiguous write burst.
// The remaining samples go into a DEPTH-entry FIFO.
// The FIFO drains in order through a read strobe whose output is registered.
module outbuf #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int PADDING = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       write,
  input  logic [WIDTH-1:0]           din,
  input  logic                       read,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (PADDING > 0) ? $clog2(PADDING + 1) : 1;

  localparam logic [SW-1:0] SKIP_INIT = SW'(PADDING);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [SW-1:0]    skip;

  logic kept;
  logic rd_ok;
  logic store;
  logic drop;

  // A sample counts as kept once the burst has already discarded its padding.
  // A read is accepted only while the FIFO holds at least one word.
  // When the FIFO is full, a kept sample can still be stored if a read frees a slot in the same cycle.
  always_comb begin
    kept  = write && (skip == '0);
    rd_ok = read && !empty;
    store = kept && (!full || rd_ok);
    drop  = kept && full && !rd_ok;
  end

  // empty and full come from the count register, so a pointer wrap can never confuse them.
  assign empty = (count == '0);
  assign full  = (count == COUNT_MAX);

  // Skip counter: any idle cycle ends the burst and reloads the counter.
  // Each write in a new burst then consumes one unit of padding.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      skip <= SKIP_INIT;
    end else if (!write) begin
      skip <= SKIP_INIT;
    end else if (skip != '0) begin
      skip <= skip - SW'(1);
    end
  end

  // FIFO storage: the contents do not matter after reset, so this array has no reset term.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wptr] <= din;
    end
  end

  // Write pointer advances once per stored word.
  // It wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
    end else if (store) begin
      wptr <= wptr + AW'(1);
    end
  end

  // Read side: an accepted read registers the head word and pulses dout_valid.
  // Otherwise dout holds its value and dout_valid drops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rptr       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (rd_ok) begin
      rptr       <= rptr + AW'(1);
      dout       <= mem[rptr];
      dout_valid <= 1'b1;
    end else begin
      dout_valid <= 1'b0;
    end
  end

  // Occupancy count: a store and a read in the same cycle leave it unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({store, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // overflow is sticky until reset.
  // It records that a kept sample was lost because the FIFO was full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_outbuf.sv
// tb_outbuf: drives two outbuf instances (PADDING=3 and PADDING=0) from one stimulus stream.
// Both instances are compared every cycle against a queue-based reference model.
module tb_outbuf;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic             write;
  logic             read;
  logic [WIDTH-1:0] din;

  logic [WIDTH-1:0] dout3, dout0;
  logic             v3, v0, e3, e0, f3, f0, o3, o0;
  logic [3:0]       c3, c0;

  int checks = 0;
  int passes = 0;

  // Reference model: one FIFO queue per instance, plus the length of the current write run.
  int q3[$];
  int q0[$];
  int run;
  int md3, md0;
  bit mv3, mv0, mo3, mo0;

  always #5 clk = ~clk;

  outbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PADDING(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .write(write), .din(din), .read(read),
    .dout(dout3), .dout_valid(v3), .empty(e3), .full(f3),
    .count(c3), .overflow(o3)
  );

  outbuf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PADDING(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .write(write), .din(din), .read(read),
    .dout(dout0), .dout_valid(v0), .empty(e0), .full(f0),
    .count(c0), .overflow(o0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic modelReset();
    q3.delete();
    q0.delete();
    run = 0;
    md3 = 0; md0 = 0;
    mv3 = 0; mv0 = 0;
    mo3 = 0; mo0 = 0;
  endtask

  // A sample is kept once PADDING earlier samples of the same burst have been seen.
  // A read pops the queue first; a kept sample is stored if the queue then has room.
  task automatic modelStep(input bit w, input int d, input bit r);
    bit k3, k0;
    k3  = w && (run >= 3);
    k0  = w;
    run = w ? run + 1 : 0;
    if (r && q3.size() > 0) begin md3 = q3.pop_front(); mv3 = 1; end
    else mv3 = 0;
    if (k3) begin
      if (q3.size() < DEPTH) q3.push_back(d);
      else mo3 = 1;
    end
    if (r && q0.size() > 0) begin md0 = q0.pop_front(); mv0 = 1; end
    else mv0 = 0;
    if (k0) begin
      if (q0.size() < DEPTH) q0.push_back(d);
      else mo0 = 1;
    end
  endtask

  task automatic checkOutput();
    chk("dout3",  dout3, md3);
    chk("valid3", v3,    mv3);
    chk("count3", c3,    q3.size());
    chk("empty3", e3,    q3.size() == 0);
    chk("full3",  f3,    q3.size() == DEPTH);
    chk("ovf3",   o3,    mo3);
    chk("dout0",  dout0, md0);
    chk("valid0", v0,    mv0);
    chk("count0", c0,    q0.size());
    chk("empty0", e0,    q0.size() == 0);
    chk("full0",  f0,    q0.size() == DEPTH);
    chk("ovf0",   o0,    mo0);
  endtask

  task automatic applyStimulus(input bit w, input int d, input bit r);
    write = w;
    din   = d[WIDTH-1:0];
    read  = r;
    @(posedge clk);
    if (rstn) modelStep(w, d, r);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    #1;
    modelReset();
    checkOutput();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    int exp4[3];
    exp4 = '{4, 5, 9};
    modelReset();

    // Reset values while held in reset, including across a clock edge.
    rstn = 1'b0; write = 1'b0; read = 1'b0; din = '0;
    #12;
    chk("rst_dout3", dout3, 0);
    chk("rst_valid3", v3, 0);
    chk("rst_empty3", e3, 1);
    chk("rst_full3", f3, 0);
    chk("rst_count3", c3, 0);
    chk("rst_ovf3", o3, 0);
    checkOutput();
    @(negedge clk);
    rstn = 1'b1;

    // Test 1: the first three samples of the burst are discarded.
    // The 4th read finds the FIFO empty and dout holds its last value.
    for (int i = 1; i <= 6; i++) applyStimulus(1, i, 0);
    chk("t1_count3", c3, 3);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1);
    chk("t1_dout3", dout3, 6);
    chk("t1_valid3", v3, 0);
    chk("t1_empty3", e3, 1);

    // Test 2: fill and overflow, then drain in order.
    for (int i = 1; i <= 12; i++) applyStimulus(1, i, 0);
    idle(1);
    chk("t2_full3", f3, 1);
    chk("t2_count3", c3, 8);
    chk("t2_ovf3", o3, 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 1);
      chk("t2_drain3", dout3, 4 + i);
    end
    chk("t2_ovf_sticky3", o3, 1);

    // Test 3: a kept write and a read in the same cycle while the FIFO is full.
    doReset();
    for (int i = 1; i <= 11; i++) applyStimulus(1, i, 0);
    applyStimulus(1, 20, 1);
    chk("t3_dout3", dout3, 4);
    chk("t3_count3", c3, 8);
    chk("t3_ovf3", o3, 0);
    for (int i = 0; i < 8; i++) applyStimulus(0, 0, 1);
    chk("t3_last3", dout3, 20);

    // Test 4: a single idle cycle breaks the burst and restarts the discard.
    for (int i = 1; i <= 5; i++) applyStimulus(1, i, 0);
    idle(1);
    for (int i = 6; i <= 9; i++) applyStimulus(1, i, 0);
    idle(1);
    chk("t4_count3", c3, 3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1);
      chk("t4_dout3", dout3, exp4[i]);
    end

    // Test 5: with PADDING=0, a write and a read in the same cycle on an empty FIFO.
    doReset();
    applyStimulus(1, 7, 1);
    chk("t5_count0", c0, 1);
    chk("t5_valid0", v0, 0);
    applyStimulus(0, 0, 1);
    chk("t5_dout0", dout0, 7);
    chk("t5_valid0b", v0, 1);

    // Test 6: asynchronous reset between clock edges with five words stored.
    doReset();
    for (int i = 1; i <= 8; i++) applyStimulus(1, i, 0);
    idle(1);
    chk("t6_count3", c3, 5);
    #3;
    rstn = 1'b0;
    #1;
    chk("t6_async_count3", c3, 0);
    chk("t6_async_empty3", e3, 1);
    chk("t6_async_count0", c0, 0);
    modelReset();
    checkOutput();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 50; i <= 53; i++) applyStimulus(1, i, 0);
    idle(1);
    chk("t6_count_after3", c3, 1);
    applyStimulus(0, 0, 1);
    chk("t6_dout3", dout3, 53);

    // Random traffic: a write-heavy phase, then a read-heavy phase, then mixed traffic.
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 255), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 255), $urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 1) == 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
